// File: rtl/act_buffer_responder.sv
// Word-addressed scratchpad that serves control-unit memory requests: a clearing sweep after reset, fixed-latency reads, single-cycle writes and range checking.
// Optional build macro MEM_WR_FWD_EN: same-cycle read+write of one word returns the new data (write-first).
module act_buffer_responder #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              RST,
   input  logic [31:0]       mem_addr,
   input  logic              mem_rd_en,
   input  logic              mem_wr_en,
   input  logic [DATA_W-1:0] mem_wr_data,
   output logic [DATA_W-1:0] mem_rd_data,
   output logic              mem_rd_valid,
   output logic              mem_ready,
   output logic              mem_err,
   output logic              dbg_state_o
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                in_range;
   logic [ADDR_W-1:0]   req_idx;
   logic                rd_acc;
   logic                wr_acc;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_widx;
   logic [DATA_W-1:0]   mem_wdat;
   logic [DATA_W-1:0]   rd_word;

   logic [RD_LAT-1:0]   vld_q, vld_d;
   logic [DATA_W-1:0]   dat_q [RD_LAT];
   logic [DATA_W-1:0]   dat_d [RD_LAT];

   assign in_range = (mem_addr[31:ADDR_W] == '0);
   assign req_idx  = mem_addr[ADDR_W-1:0];

   // Handshake: a request is taken on any edge where mem_ready is high; there is no
   // back-pressure, and mem_rd_valid is a one-cycle pulse RD_LAT cycles after its read.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      err_d    = 1'b0;
      rd_acc   = 1'b0;
      wr_acc   = 1'b0;
      mem_we   = 1'b0;
      mem_widx = ptr_q;
      mem_wdat = '0;
      case (state_q)
         ST_CLEAR: begin
            mem_we = 1'b1;
            ptr_d  = ptr_q + ADDR_W'(1);
            err_d  = mem_rd_en | mem_wr_en;
            if (ptr_q == LAST_PTR) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // Out-of-range reads still occupy a pipeline slot and return zero.
            rd_acc = mem_rd_en;
            wr_acc = mem_wr_en & in_range;
            err_d  = (mem_rd_en | mem_wr_en) & ~in_range;
            if (wr_acc) begin
               mem_we   = 1'b1;
               mem_widx = req_idx;
               mem_wdat = mem_wr_data;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   always_comb begin
      rd_word = '0;
      if (in_range) begin
         rd_word = mem_q[req_idx];
      end
`ifdef MEM_WR_FWD_EN
      if (wr_acc) begin
         rd_word = mem_wr_data;
      end
`else
`endif
   end

   // Each stage only takes new data alongside a valid, so the last stage holds its value.
   always_comb begin
      vld_d = '0;
      for (int i = 0; i < RD_LAT; i++) begin
         dat_d[i] = dat_q[i];
      end
      vld_d[0] = rd_acc;
      if (rd_acc) begin
         dat_d[0] = rd_word;
      end
      for (int i = 1; i < RD_LAT; i++) begin
         vld_d[i] = vld_q[i-1];
         if (vld_q[i-1]) begin
            dat_d[i] = dat_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state_q <= ST_CLEAR;
         ptr_q   <= '0;
         err_q   <= 1'b0;
         vld_q   <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            dat_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         err_q   <= err_d;
         vld_q   <= vld_d;
         for (int i = 0; i < RD_LAT; i++) begin
            dat_q[i] <= dat_d[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!RST && mem_we) begin
         mem_q[mem_widx] <= mem_wdat;
      end
   end

   assign mem_rd_valid = vld_q[RD_LAT-1];
   assign mem_rd_data  = dat_q[RD_LAT-1];
   assign mem_ready    = (state_q == ST_RUN);
   assign mem_err      = err_q;
   assign dbg_state_o  = state_q;

endmodule
